// File: rtl/nand_id_responder.sv
// Purpose: device-side NAND target that answers READ ID (90h), READ STATUS (70h) and RESET (FFh).
// Latency: 2 clks from a host pin edge to io_out/io_oe (one pin sample stage + one output register).
// Backpressure: none on the bus; rb_n=0 during the post-RESET busy window, in which only 70h is honoured.
// Ports: clk, reset (sync, active high); host pins nCE/CLE/ALE/nWE/nRE/io_in;
//        io_out/io_oe drive the shared IO bus; rb_n ready/busy#; id_done/bad_cmd 1-clk pulses;
//        state_dbg exposes the FSM state (0 idle, 1 id_addr, 2 id_out, 3 st_out, 4 busy).
module nand_id_responder #(
  parameter logic [7:0]  ID_B0    = 8'hEC,
  parameter logic [7:0]  ID_B1    = 8'hD3,
  parameter logic [7:0]  ID_B2    = 8'h51,
  parameter logic [7:0]  ID_B3    = 8'h95,
  parameter int unsigned RST_BUSY = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nCE,
  input  logic       CLE,
  input  logic       ALE,
  input  logic       nWE,
  input  logic       nRE,
  input  logic [7:0] io_in,
  output logic [7:0] io_out,
  output logic       io_oe,
  output logic       rb_n,
  output logic       id_done,
  output logic       bad_cmd,
  output logic [2:0] state_dbg
);

  localparam int unsigned CW = (RST_BUSY > 1) ? $clog2(RST_BUSY) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(RST_BUSY - 1);

  localparam logic [7:0] CMD_READ_ID = 8'h90;
  localparam logic [7:0] CMD_STATUS  = 8'h70;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ID_ADDR = 3'd1,
    S_ID_OUT  = 3'd2,
    S_ST_OUT  = 3'd3,
    S_BUSY    = 3'd4
  } state_t;

  // Pin sample stage (p_*) and one-clock-older copies of the strobes (q_*).
  logic       p_nce, p_cle, p_ale, p_nwe, p_nre;
  logic [7:0] p_io;
  logic       q_nwe, q_nre;

  always_ff @(posedge clk) begin
    if (reset) begin
      p_nce <= 1'b1;
      p_cle <= 1'b0;
      p_ale <= 1'b0;
      p_nwe <= 1'b1;
      p_nre <= 1'b1;
      p_io  <= 8'h00;
      q_nwe <= 1'b1;
      q_nre <= 1'b1;
    end else begin
      p_nce <= nCE;
      p_cle <= CLE;
      p_ale <= ALE;
      p_nwe <= nWE;
      p_nre <= nRE;
      p_io  <= io_in;
      q_nwe <= p_nwe;
      q_nre <= p_nre;
    end
  end

  logic we_rise, re_fall, re_rise;
  logic cmd_cyc, adr_cyc, rd_fall, rd_rise;

  always_comb begin
    we_rise = ~q_nwe & p_nwe & ~p_nce;
    re_fall = q_nre & ~p_nre & ~p_nce;
    re_rise = ~q_nre & p_nre & ~p_nce;
    cmd_cyc = we_rise & p_cle & ~p_ale;
    adr_cyc = we_rise & ~p_cle & p_ale;
    // A write strobe edge takes priority; a read edge in the same clock is dropped.
    rd_fall = re_fall & ~we_rise;
    rd_rise = re_rise & ~we_rise;
  end

  function automatic logic [7:0] id_byte(input logic [7:0] a, input logic [1:0] i);
    logic [7:0] b;
    b = 8'h00;
    if (a == 8'h00) begin
      case (i)
        2'd0:    b = ID_B0;
        2'd1:    b = ID_B1;
        2'd2:    b = ID_B2;
        default: b = ID_B3;
      endcase
    end else if (a == 8'h20) begin
      case (i)
        2'd0:    b = 8'h4F;
        2'd1:    b = 8'h4E;
        2'd2:    b = 8'h46;
        default: b = 8'h49;
      endcase
    end
    return b;
  endfunction

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    byte_idx, byte_nxt;
  logic [7:0]    addr, addr_nxt;
  logic [7:0]    io_out_nxt;
  logic          oe_want, io_oe_nxt;
  logic          rb_nxt, id_done_nxt, bad_nxt;
  logic          st_busy, st_busy_nxt;   // 70h seen while busy: serve status reads

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    byte_nxt    = byte_idx;
    addr_nxt    = addr;
    io_out_nxt  = io_out;
    oe_want     = io_oe;
    rb_nxt      = rb_n;
    id_done_nxt = 1'b0;
    bad_nxt     = 1'b0;
    st_busy_nxt = st_busy;

    case (state)
      S_BUSY: begin
        // Strobe handling first; the busy countdown below may still override the drive.
        if (p_nce) begin
          oe_want = 1'b0;
        end else if (cmd_cyc) begin
          oe_want = 1'b0;
          if (p_io == CMD_STATUS) st_busy_nxt = 1'b1;
        end else if (st_busy && rd_fall) begin
          io_out_nxt = rb_n ? 8'hE0 : 8'h80;
          oe_want    = 1'b1;
        end else if (st_busy && rd_rise) begin
          oe_want = 1'b0;
        end

        // rb_n rises when the count hits zero; the clock after that returns to idle.
        if (rb_n) begin
          state_nxt   = S_IDLE;
          st_busy_nxt = 1'b0;
          oe_want     = 1'b0;
        end else if (cnt == '0) begin
          rb_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end

      default: begin
        if (p_nce) begin
          state_nxt = S_IDLE;
          oe_want   = 1'b0;
        end else if (cmd_cyc) begin
          oe_want = 1'b0;
          case (p_io)
            CMD_READ_ID: state_nxt = S_ID_ADDR;
            CMD_STATUS:  state_nxt = S_ST_OUT;
            CMD_RESET: begin
              state_nxt   = S_BUSY;
              rb_nxt      = 1'b0;
              cnt_nxt     = CNT_INIT;
              st_busy_nxt = 1'b0;
            end
            default: begin
              state_nxt = S_IDLE;
              bad_nxt   = 1'b1;
            end
          endcase
        end else begin
          case (state)
            S_IDLE: ;
            S_ID_ADDR: begin
              if (adr_cyc) begin
                addr_nxt  = p_io;
                byte_nxt  = 2'd0;
                state_nxt = S_ID_OUT;
              end
            end
            S_ID_OUT: begin
              if (rd_fall) begin
                io_out_nxt = id_byte(addr, byte_idx);
                oe_want    = 1'b1;
              end else if (rd_rise) begin
                oe_want     = 1'b0;
                byte_nxt    = byte_idx + 2'd1;
                id_done_nxt = (byte_idx == 2'd3);
              end
            end
            S_ST_OUT: begin
              if (rd_fall) begin
                io_out_nxt = rb_n ? 8'hE0 : 8'h80;
                oe_want    = 1'b1;
              end else if (rd_rise) begin
                oe_want = 1'b0;
              end
            end
            default: state_nxt = S_IDLE;
          endcase
        end
      end
    endcase

    // Gate with the raw pins, which are what p_nwe/p_nce take on at the same edge,
    // so io_oe can never be high while the sampled nWE is low or nCE is high.
    io_oe_nxt = oe_want & nWE & ~nCE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      byte_idx <= 2'd0;
      addr     <= 8'h00;
      io_out   <= 8'h00;
      io_oe    <= 1'b0;
      rb_n     <= 1'b1;
      id_done  <= 1'b0;
      bad_cmd  <= 1'b0;
      st_busy  <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      byte_idx <= byte_nxt;
      addr     <= addr_nxt;
      io_out   <= io_out_nxt;
      io_oe    <= io_oe_nxt;
      rb_n     <= rb_nxt;
      id_done  <= id_done_nxt;
      bad_cmd  <= bad_nxt;
      st_busy  <= st_busy_nxt;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_nand_id_responder.sv
// Purpose: self-checking bench for nand_id_responder; host transactions against a transaction-level model.
// Latency: outputs sampled at negedges two clocks after each host pin edge.
// Backpressure: busy windows are modelled by cycle stamps; host waits for ready before long sequences.
module tb_nand_id_responder;

  localparam int RST_BUSY = 16;
  localparam int S_IDLE = 0, S_ID_ADDR = 1, S_ID_OUT = 2, S_ST_OUT = 3, S_BUSY = 4;

  logic       clk = 1'b0, reset = 1'b1;
  logic       nCE = 1'b0, CLE = 1'b0, ALE = 1'b0, nWE = 1'b1, nRE = 1'b1;
  logic [7:0] io_in = 8'h00;
  logic [7:0] io_out;
  logic       io_oe, rb_n, id_done, bad_cmd;
  logic [2:0] state_dbg;

  nand_id_responder #(.RST_BUSY(RST_BUSY)) dut (
    .clk(clk), .reset(reset), .nCE(nCE), .CLE(CLE), .ALE(ALE), .nWE(nWE), .nRE(nRE),
    .io_in(io_in), .io_out(io_out), .io_oe(io_oe), .rb_n(rb_n), .id_done(id_done),
    .bad_cmd(bad_cmd), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0;

  // Reference model state
  int         m_state = S_IDLE;
  logic [7:0] m_addr = 8'h00;
  int         m_idx = 0;
  bit         m_bstat = 1'b0;
  bit         busy_on = 1'b0;
  int         busy_c = 0;
  logic [7:0] id_tab   [4] = '{8'hEC, 8'hD3, 8'h51, 8'h95};
  logic [7:0] onfi_tab [4] = '{8'h4F, 8'h4E, 8'h46, 8'h49};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [7:0] id_val(input logic [7:0] a, input int i);
    if (a == 8'h00) return id_tab[i];
    if (a == 8'h20) return onfi_tab[i];
    return 8'h00;
  endfunction

  // rb_n is low for RST_BUSY consecutive clocks starting 2 clocks after the FFh nWE rise.
  function automatic logic exp_rb();
    return !(busy_on && cyc >= busy_c + 2 && cyc < busy_c + 2 + RST_BUSY);
  endfunction

  // The device leaves busy one clock after rb_n rises; an operation started at cycle c
  // is judged by the device at c+2.
  function automatic void model_sync();
    if (m_state == S_BUSY && cyc > busy_c + 1 + RST_BUSY) begin
      m_state = S_IDLE;
      m_bstat = 1'b0;
    end
  endfunction

  function automatic void model_cmd(input logic [7:0] b, input int c, output bit bad);
    bad = 1'b0;
    if (m_state == S_BUSY) begin
      if (b == 8'h70) m_bstat = 1'b1;
    end else if (b == 8'h90) m_state = S_ID_ADDR;
    else if (b == 8'h70) m_state = S_ST_OUT;
    else if (b == 8'hFF) begin
      m_state = S_BUSY; busy_c = c; busy_on = 1'b1; m_bstat = 1'b0;
    end else begin
      m_state = S_IDLE; bad = 1'b1;
    end
  endfunction

  // Bench-side copies of the sampled pins, for the bus-contention rule.
  logic tb_p_nwe = 1'b1, tb_p_nce = 1'b1;
  bit   mon_en = 1'b0;
  int   lo_run = 0, last_lo = 0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    tb_p_nwe <= nWE;
    tb_p_nce <= nCE;
  end

  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check("rb_n", rb_n, exp_rb());
      check("bus_contention", io_oe & (~tb_p_nwe | tb_p_nce), 1'b0);
      if (!rb_n) lo_run++;
      else begin
        if (lo_run != 0) last_lo = lo_run;
        lo_run = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_ready();
    int guard = 0;
    while (m_state == S_BUSY && cyc <= busy_c + 3 + RST_BUSY && guard < 200) begin
      tick(1);
      guard++;
    end
    model_sync();
  endtask

  // Keep operations clear of the end of a busy window.
  task automatic busy_guard();
    if (m_state == S_BUSY && cyc > busy_c + 10) wait_ready();
  endtask

  task automatic host_cycle(input logic cle, input logic ale, input logic [7:0] b);
    int c;
    bit exp_bad;
    busy_guard();
    model_sync();
    CLE = cle; ALE = ale; io_in = b; nWE = 1'b0;
    tick($urandom_range(2, 4));
    c = cyc;
    nWE = 1'b1;
    exp_bad = 1'b0;
    if (cle && !ale) model_cmd(b, c, exp_bad);
    else if (!cle && ale && m_state == S_ID_ADDR) begin
      m_addr = b; m_idx = 0; m_state = S_ID_OUT;
    end
    tick(2);
    check("bad_cmd", bad_cmd, exp_bad);
    check("state_after_we", state_dbg, m_state);
    check("io_oe_after_we", io_oe, 1'b0);
    tick(1);
    check("bad_cmd_width", bad_cmd, 1'b0);
    CLE = 1'b0; ALE = 1'b0;
  endtask

  task automatic host_read();
    bit exp_oe, exp_done;
    logic [7:0] exp_d;
    busy_guard();
    model_sync();
    exp_oe = 1'b0; exp_d = 8'h00; exp_done = 1'b0;
    case (m_state)
      S_ID_OUT: begin exp_oe = 1'b1; exp_d = id_val(m_addr, m_idx); end
      S_ST_OUT: begin exp_oe = 1'b1; exp_d = 8'hE0; end
      S_BUSY:   if (m_bstat) begin exp_oe = 1'b1; exp_d = 8'h80; end
      default: ;
    endcase
    nRE = 1'b0;
    tick(2);
    check("io_oe_read", io_oe, exp_oe);
    if (exp_oe) check("io_out", io_out, exp_d);
    tick($urandom_range(0, 2));
    if (exp_oe) check("io_out_hold", io_out, exp_d);
    nRE = 1'b1;
    if (m_state == S_ID_OUT) begin
      exp_done = (m_idx == 3);
      m_idx = (m_idx + 1) % 4;
    end
    tick(2);
    check("io_oe_release", io_oe, 1'b0);
    check("id_done", id_done, exp_done);
    check("state_after_read", state_dbg, m_state);
    tick(1);
    check("id_done_width", id_done, 1'b0);
  endtask

  task automatic host_deselect();
    busy_guard();
    model_sync();
    if (m_state != S_BUSY) m_state = S_IDLE;
    nCE = 1'b1;
    tick(2);
    check("io_oe_deselect", io_oe, 1'b0);
    check("state_deselect", state_dbg, m_state);
    nCE = 1'b0;
    tick(2);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_state = S_IDLE; m_addr = 8'h00; m_idx = 0; m_bstat = 1'b0; busy_on = 1'b0;
    tick(1);
    check("rst_rb_n", rb_n, 1'b1);
    check("rst_io_oe", io_oe, 1'b0);
    check("rst_io_out", io_out, 8'h00);
    check("rst_state", state_dbg, S_IDLE);
    check("rst_id_done", id_done, 1'b0);
    check("rst_bad_cmd", bad_cmd, 1'b0);
    reset = 1'b0; nRE = 1'b1; nWE = 1'b1; nCE = 1'b0; CLE = 1'b0; ALE = 1'b0;
    tick(2);
  endtask

  function automatic logic [7:0] pick_addr();
    case ($urandom_range(0, 3))
      0, 3:    return 8'h00;
      1:       return 8'h20;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    do_reset();
    mon_en = 1'b1;

    // T1: manufacturer ID
    host_cycle(1'b1, 1'b0, 8'h90);
    host_cycle(1'b0, 1'b1, 8'h00);
    repeat (4) host_read();

    // T2: ONFI signature with wrap on the fifth read
    host_cycle(1'b1, 1'b0, 8'h90);
    host_cycle(1'b0, 1'b1, 8'h20);
    repeat (5) host_read();

    // T3: reset busy window, status while busy and after ready
    host_cycle(1'b1, 1'b0, 8'hFF);
    host_cycle(1'b1, 1'b0, 8'h70);
    host_read();
    wait_ready();
    tick(2);
    check("busy_length", last_lo, RST_BUSY);
    host_cycle(1'b1, 1'b0, 8'h70);
    host_read();
    host_read();

    // T4: unsupported command
    host_cycle(1'b1, 1'b0, 8'h35);
    host_read();

    // T5: deselect after two ID bytes, then mid-read, then restart
    host_cycle(1'b1, 1'b0, 8'h90);
    host_cycle(1'b0, 1'b1, 8'h00);
    host_read();
    host_read();
    host_deselect();
    host_cycle(1'b1, 1'b0, 8'h90);
    host_cycle(1'b0, 1'b1, 8'h00);
    nRE = 1'b0;
    tick(2);
    check("t5_oe_before_deselect", io_oe, 1'b1);
    check("t5_first_byte", io_out, 8'hEC);
    nCE = 1'b1;
    m_state = S_IDLE;
    tick(1);
    check("t5_oe_deselect", io_oe, 1'b0);
    tick(1);
    check("t5_state_idle", state_dbg, S_IDLE);
    nRE = 1'b1;
    tick(2);
    nCE = 1'b0;
    tick(2);
    host_cycle(1'b1, 1'b0, 8'h90);
    host_cycle(1'b0, 1'b1, 8'h00);
    host_read();

    // T6: reset mid-BUSY and mid-ID_OUT
    host_cycle(1'b1, 1'b0, 8'hFF);
    tick(5);
    do_reset();
    host_cycle(1'b1, 1'b0, 8'h90);
    host_cycle(1'b0, 1'b1, 8'h00);
    nRE = 1'b0;
    tick(2);
    check("t6_oe_before_reset", io_oe, 1'b1);
    do_reset();

    // Randomized host traffic
    for (int n = 0; n < 200; n++) begin
      tick($urandom_range(0, 2));
      case ($urandom_range(0, 9))
        0, 1: begin
          host_cycle(1'b1, 1'b0, 8'h90);
          host_cycle(1'b0, 1'b1, pick_addr());
          repeat ($urandom_range(1, 6)) host_read();
        end
        2: begin
          host_cycle(1'b1, 1'b0, 8'h70);
          repeat ($urandom_range(1, 3)) host_read();
        end
        3: begin
          host_cycle(1'b1, 1'b0, 8'hFF);
          if ($urandom_range(0, 1) == 1) begin
            host_cycle(1'b1, 1'b0, 8'h70);
            host_read();
          end
        end
        4: host_cycle(1'b1, 1'b0, 8'($urandom_range(0, 255)));
        5: host_cycle(1'b0, 1'b1, pick_addr());
        6: host_read();
        7: begin
          if ($urandom_range(0, 1) == 1) host_cycle(1'b1, 1'b1, 8'($urandom_range(0, 255)));
          else host_cycle(1'b0, 1'b0, 8'($urandom_range(0, 255)));
        end
        8: host_deselect();
        default: repeat ($urandom_range(1, 2)) host_read();
      endcase
    end
    wait_ready();
    tick(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
